fifo: RTL and testbench
=======================

Name: fifo

Overview:
- Synchronous single-clock first-in first-out buffer for byte-wide data.
- Used as a rate-decoupling queue between a producer and a consumer in the same clock domain.
- Provides a registered read-data output, full/empty status flags and an occupancy count.

Parameters:
- DATA_WIDTH, 8, width of data_in and data_out in bits.
- DEPTH, 8, number of storage entries; must be a power of two and at least 2.
- ADDR_WIDTH, 3, pointer width; must equal log2(DEPTH).

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- reset  input  1  asynchronous active-low reset (0 = reset).
- read  input  1  read request, sampled on the rising clk edge.
- write  input  1  write request, sampled on the rising clk edge.
- data_in  input  DATA_WIDTH  write data, sampled on the rising clk edge when a write is accepted.
- data_out  output  DATA_WIDTH  registered read data.
- full  output  1  high when count == DEPTH.
- empty  output  1  high when count == 0.
- count  output  ADDR_WIDTH+1  current number of stored entries, 0..DEPTH.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, port named reset.
- Reset (reset = 0, takes effect immediately, independent of clk):
  - write pointer, read pointer and count = 0.
  - data_out = 0, empty = 1, full = 0.
  - Storage array contents need not be cleared.
- Reset release is synchronous to normal operation: the first rising clk edge with reset = 1 may accept requests.
- Write acceptance: accepted at a rising edge when write = 1 and the FIFO is not full.
  - Exception: when full, a write is also accepted if a read is accepted in the same cycle.
  - On acceptance, data_in is stored at the write pointer and the write pointer increments modulo DEPTH.
- Read acceptance: accepted at a rising edge when read = 1 and empty = 0.
  - On acceptance, the entry at the read pointer is loaded into data_out and the read pointer increments modulo DEPTH.
  - Latency: data_out shows the new word right after the accepting edge, i.e. one cycle after read is sampled.
- data_out holds its last value whenever no read is accepted.
- Write while full with no accepted read: ignored; storage, pointers and count are unchanged.
- Read while empty: ignored; data_out holds, pointers and count are unchanged.
- Simultaneous accepted read and write: both pointers advance and count is unchanged.
- Simultaneous read and write while empty: only the write is accepted, with no bypass.
  - data_out is unchanged.
  - count becomes 1 and empty deasserts after that edge.
- count update per edge: +1 on write-only, -1 on read-only, 0 on both or neither.
- Flags: full and empty are decoded from the registered count, so they are glitch-free and valid one edge after the causing operation.
- Pointer wrap-around: pointers roll from DEPTH-1 to 0 without disturbing data order; FIFO order is preserved across any number of wraps.
- Asserting reset mid-operation discards all queued data immediately; the FIFO reads as empty after release.
- Output ordering: words are read out in exactly the order they were accepted.

Test Plan:
- Assert reset low for 2 cycles -> empty = 1, full = 0, count = 0, data_out = 0. Then release.
- Write 1, 2, 3, 4 on consecutive edges, then assert read for 4 cycles:
  - count goes to 4 during the writes.
  - data_out = 1, 2, 3, 4 on the edges after each read.
  - empty = 1 and count = 0 after the 4th read.
- Write 8 words 0x10..0x17 -> full = 1 after the 8th edge. A 9th write of 0xFF is ignored (count stays 8). Draining yields 0x10..0x17 in order.
- From empty, assert read and write together with data_in = 5 -> only the write is accepted: count = 1, data_out unchanged. A following read returns 5.
- With 3 entries queued, assert read and write for 10 cycles with incrementing data -> count stays 3. Pointers wrap and the output order is preserved.
- Write 2 words, then pull reset low between clock edges -> empty = 1 and data_out = 0 immediately, with no clk edge needed. After release, a read leaves data_out = 0.

Source files
------------

// File: rtl/fifo.sv
// Single-clock byte FIFO with registered read data.
// Flags are decoded from the registered occupancy count.
module fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  read,
    input  logic                  write,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count
);

    localparam logic [ADDR_WIDTH:0]   CntFull = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   CntOne  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PtrOne  = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;

    logic rd_acc;
    logic wr_acc;

    assign full     = (count_q == CntFull);
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign data_out = dout_q;

    // A full FIFO still takes a write when a read frees a slot this edge.
    assign rd_acc = read & ~empty;
    assign wr_acc = write & (~full | rd_acc);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end

        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
            dout_d   = mem_q[rd_ptr_q];
        end

        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

endmodule

// File: tb/tb_fifo.sv
// Scoreboard bench for the byte FIFO.
// A queue model predicts occupancy and read order.
module tb_fifo;

    logic       clk;
    logic       reset;
    logic       read;
    logic       write;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       full;
    logic       empty;
    logic [3:0] count;

    int n_cmp;
    int n_fail;

    logic [7:0] mdl[$];
    logic [7:0] exp_q[$];
    logic [7:0] dout_mdl;

    fifo #(
        .DATA_WIDTH(8),
        .DEPTH(8),
        .ADDR_WIDTH(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .read(read),
        .write(write),
        .data_in(data_in),
        .data_out(data_out),
        .full(full),
        .empty(empty),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge; the model predicts which requests are accepted.
    task automatic drive(input logic r, input logic w, input logic [7:0] d);
        logic rd;
        logic wr;
        read    = r;
        write   = w;
        data_in = d;
        rd = r && (mdl.size() > 0);
        wr = w && ((mdl.size() < 8) || rd);
        @(posedge clk);
        #1;
        if (rd) begin
            dout_mdl = mdl.pop_front();
            exp_q.push_back(dout_mdl);
        end
        if (wr) mdl.push_back(d);
        read  = 1'b0;
        write = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (empty !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_empty: got %b want 1", empty);
        end
        n_cmp++;
        if (full !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_full: got %b want 0", full);
        end
        n_cmp++;
        if (count !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_count: got %0d want 0", count);
        end
        n_cmp++;
        if (data_out !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_dout: got %h want 00", data_out);
        end
        reset = 1'b1;
    endtask

    task automatic test_basic();
        logic [7:0] e;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b0, 1'b1, 8'(i));
            n_cmp++;
            if (count !== 4'(mdl.size())) begin
                n_fail++;
                $display("FAIL basic_wcount: got %0d want %0d", count, mdl.size());
            end
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 8'h00);
            e = exp_q.size() > 0 ? exp_q.pop_front() : 8'hxx;
            n_cmp++;
            if (data_out !== e) begin
                n_fail++;
                $display("FAIL basic_dout: got %h want %h", data_out, e);
            end
        end
        n_cmp++;
        if (empty !== 1'b1 || count !== 4'd0) begin
            n_fail++;
            $display("FAIL basic_drained: got empty=%b count=%0d want 1/0",
                     empty, count);
        end
    endtask

    task automatic test_full();
        logic [7:0] e;
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 8'(8'h10 + i));
        n_cmp++;
        if (full !== 1'b1 || count !== 4'd8) begin
            n_fail++;
            $display("FAIL full_flag: got full=%b count=%0d want 1/8", full, count);
        end
        drive(1'b0, 1'b1, 8'hFF);
        n_cmp++;
        if (count !== 4'd8 || full !== 1'b1) begin
            n_fail++;
            $display("FAIL full_ignore: got count=%0d full=%b want 8/1", count, full);
        end
        drive(1'b1, 1'b1, 8'hAA);
        n_cmp++;
        if (count !== 4'd8) begin
            n_fail++;
            $display("FAIL full_rw_count: got %0d want 8", count);
        end
        while (mdl.size() > 0 || exp_q.size() > 0) begin
            if (exp_q.size() == 0) drive(1'b1, 1'b0, 8'h00);
            e = exp_q.pop_front();
            n_cmp++;
            if (data_out !== e) begin
                n_fail++;
                $display("FAIL full_drain: got %h want %h", data_out, e);
            end
        end
        n_cmp++;
        if (empty !== 1'b1) begin
            n_fail++;
            $display("FAIL full_drained: got empty=%b want 1", empty);
        end
    endtask

    task automatic test_rw_empty();
        logic [7:0] e;
        drive(1'b1, 1'b1, 8'h05);
        n_cmp++;
        if (count !== 4'd1 || empty !== 1'b0) begin
            n_fail++;
            $display("FAIL rwe_count: got count=%0d empty=%b want 1/0", count, empty);
        end
        n_cmp++;
        if (data_out !== dout_mdl) begin
            n_fail++;
            $display("FAIL rwe_hold: got %h want %h", data_out, dout_mdl);
        end
        drive(1'b1, 1'b0, 8'h00);
        e = exp_q.size() > 0 ? exp_q.pop_front() : 8'hxx;
        n_cmp++;
        if (data_out !== e || e !== 8'h05) begin
            n_fail++;
            $display("FAIL rwe_read: got %h want 05", data_out);
        end
        drive(1'b1, 1'b0, 8'h00);
        n_cmp++;
        if (data_out !== 8'h05 || count !== 4'd0) begin
            n_fail++;
            $display("FAIL rwe_idle_read: got %h count=%0d want 05/0", data_out, count);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] e;
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 8'(8'h30 + i));
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b1, 8'(8'h40 + i));
            e = exp_q.size() > 0 ? exp_q.pop_front() : 8'hxx;
            n_cmp++;
            if (data_out !== e) begin
                n_fail++;
                $display("FAIL b2b_dout: got %h want %h", data_out, e);
            end
            n_cmp++;
            if (count !== 4'd3) begin
                n_fail++;
                $display("FAIL b2b_count: got %0d want 3", count);
            end
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 8'h00);
            e = exp_q.size() > 0 ? exp_q.pop_front() : 8'hxx;
            n_cmp++;
            if (data_out !== e) begin
                n_fail++;
                $display("FAIL b2b_drain: got %h want %h", data_out, e);
            end
        end
    endtask

    task automatic test_async_reset();
        drive(1'b0, 1'b1, 8'hC1);
        drive(1'b0, 1'b1, 8'hC2);
        #2;
        reset = 1'b0;
        mdl.delete();
        exp_q.delete();
        dout_mdl = 8'h00;
        #1;
        n_cmp++;
        if (empty !== 1'b1 || count !== 4'd0) begin
            n_fail++;
            $display("FAIL arst_flags: got empty=%b count=%0d want 1/0", empty, count);
        end
        n_cmp++;
        if (data_out !== 8'h00) begin
            n_fail++;
            $display("FAIL arst_dout: got %h want 00", data_out);
        end
        @(negedge clk);
        reset = 1'b1;
        drive(1'b1, 1'b0, 8'h00);
        n_cmp++;
        if (data_out !== 8'h00 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL arst_read: got %h empty=%b want 00/1", data_out, empty);
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_fail   = 0;
        dout_mdl = 8'h00;
        reset    = 1'b0;
        read     = 1'b0;
        write    = 1'b0;
        data_in  = 8'h00;
        test_reset();
        test_basic();
        test_full();
        test_rw_empty();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
